// File: rtl/lsram_package.sv
// LSRAM geometry helpers plus the round-robin pick function that the port
// schedulers share.
package LSRAM_package;

    typedef enum logic [2:0] {
        MODE_16KX1,
        MODE_8KX2,
        MODE_4KX4,
        MODE_2KX9,
        MODE_1KX18,
        MODE_512X36
    } mode_type;

    function automatic int data_width_fn(input mode_type mode);
        case (mode)
            MODE_16KX1:  return 1;
            MODE_8KX2:   return 2;
            MODE_4KX4:   return 4;
            MODE_2KX9:   return 9;
            MODE_1KX18:  return 18;
            MODE_512X36: return 36;
            default:     return 18;
        endcase
    endfunction

    function automatic int addr_width_fn(input mode_type mode);
        case (mode)
            MODE_16KX1:  return 14;
            MODE_8KX2:   return 13;
            MODE_4KX4:   return 12;
            MODE_2KX9:   return 11;
            MODE_1KX18:  return 10;
            MODE_512X36: return 9;
            default:     return 10;
        endcase
    endfunction

    localparam int RR_MAX_REQ = 8;
    localparam int RR_IDX_W   = 3;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] index;
    } rr_pick_t;

    // First set bit of valid scanning ptr, ptr+1, ... modulo num_req.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                         input logic [RR_IDX_W-1:0]   ptr,
                                         input int unsigned           num_req);
        rr_pick_t            pick;
        int unsigned         idx;
        logic [RR_IDX_W-1:0] idx_w;
        pick = '0;
        for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
            idx   = (32'(ptr) + k) % num_req;
            idx_w = idx[RR_IDX_W-1:0];
            if (k < num_req && !pick.found && valid[idx_w]) begin
                pick.found = 1'b1;
                pick.index = idx_w;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/lsram_rr_arbiter.sv
// Round-robin grant with an optional per-requester lock; grant and ready are
// combinational, the pointer and lock state are registered.
module lsram_rr_arbiter
    import LSRAM_package::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_lock,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       gnt_valid,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       lock_owner_q, lock_owner_d;
    logic                  locked_q, locked_d;
    logic [RR_MAX_REQ-1:0] valid_ext;
    logic [RR_IDX_W-1:0]   ptr_ext;
    rr_pick_t              pick;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = req_valid;
        ptr_ext                  = '0;
        ptr_ext[ID_W-1:0]        = ptr_q;
        pick                     = rr_pick(valid_ext, ptr_ext, NUM_REQ);

        // A locked port only serves its owner; an idle owner yields a bubble.
        if (locked_q) begin
            gnt_valid = req_valid[lock_owner_q];
            gnt_idx   = lock_owner_q;
        end else begin
            gnt_valid = pick.found;
            gnt_idx   = pick.index[ID_W-1:0];
        end
        if (!aresetn) begin
            gnt_valid = 1'b0;
        end

        req_ready = '0;
        if (gnt_valid) begin
            req_ready[gnt_idx] = 1'b1;
        end

        ptr_d        = ptr_q;
        locked_d     = locked_q;
        lock_owner_d = lock_owner_q;
        if (gnt_valid) begin
            ptr_d        = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            locked_d     = req_lock[gnt_idx];
            lock_owner_d = gnt_idx;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is
    // sampled on the clock edge rather than in the sensitivity list.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ptr_q        <= '0;
            locked_q     <= 1'b0;
            lock_owner_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            locked_q     <= locked_d;
            lock_owner_q <= lock_owner_d;
        end
    end

endmodule

// File: rtl/lsram_port_arbiter.sv
// Shares LSRAM port A between NUM_REQ requesters: registered command stage and
// a two-deep tag pipeline that steers read data back to its issuer.
module lsram_port_arbiter
    import LSRAM_package::*;
#(
    parameter int       NUM_REQ    = 4,
    parameter mode_type MODE       = MODE_1KX18,
    parameter int       DATA_WIDTH = data_width_fn(MODE),
    parameter int       ADDR_WIDTH = addr_width_fn(MODE)
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0]                 req_we,
    input  logic [NUM_REQ-1:0]                 req_lock,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [DATA_WIDTH-1:0]              rsp_rdata,
    output logic                               ram_we,
    output logic [ADDR_WIDTH-1:0]              ram_addr,
    output logic [DATA_WIDTH-1:0]              ram_din,
    input  logic [DATA_WIDTH-1:0]              ram_dout,
    output logic [$clog2(NUM_REQ)-1:0]         gnt_id
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic                  gnt_valid;
    logic [ID_W-1:0]       gnt_idx;

    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
    logic [ID_W-1:0]       gnt_id_q, gnt_id_d;
    logic                  tag1_rd_q, tag1_rd_d, tag2_rd_q, tag2_rd_d;
    logic [ID_W-1:0]       tag1_id_q, tag1_id_d, tag2_id_q, tag2_id_d;

    lsram_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        gnt_id_d   = gnt_id_q;
        tag1_rd_d  = 1'b0;
        tag1_id_d  = gnt_idx;
        if (gnt_valid) begin
            ram_we_d   = req_we[gnt_idx];
            ram_addr_d = req_addr[gnt_idx];
            ram_din_d  = req_wdata[gnt_idx];
            gnt_id_d   = gnt_idx;
            tag1_rd_d  = !req_we[gnt_idx];
        end
        // Stage 2 lines up with the RAM's registered read data.
        tag2_rd_d = tag1_rd_q;
        tag2_id_d = tag1_id_q;

        rsp_valid = '0;
        if (tag2_rd_q) begin
            rsp_valid[tag2_id_q] = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            gnt_id_q   <= '0;
            tag1_rd_q  <= 1'b0;
            tag1_id_q  <= '0;
            tag2_rd_q  <= 1'b0;
            tag2_id_q  <= '0;
        end else begin
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            gnt_id_q   <= gnt_id_d;
            tag1_rd_q  <= tag1_rd_d;
            tag1_id_q  <= tag1_id_d;
            tag2_rd_q  <= tag2_rd_d;
            tag2_id_q  <= tag2_id_d;
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign gnt_id    = gnt_id_q;
    assign rsp_rdata = ram_dout;

endmodule

// File: tb/tb_lsram_port_arbiter.sv
// Directed bench for lsram_port_arbiter with a behavioural 1Kx18 RAM on port A.
module tb_lsram_port_arbiter;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [3:0]        req_valid, req_ready, req_we, req_lock, rsp_valid;
    logic [3:0][9:0]   req_addr;
    logic [3:0][17:0]  req_wdata;
    logic [17:0]       rsp_rdata, ram_din, ram_dout;
    logic              ram_we;
    logic [9:0]        ram_addr;
    logic [1:0]        gnt_id;
    logic [17:0]       mem [1024];

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    lsram_port_arbiter dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .gnt_id    (gnt_id)
    );

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        ram_dout = '0;
    end

    always @(posedge aclk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_we    = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clear_inputs();
        cyc();
        cyc();
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        aresetn   = 1'b0;
        clear_inputs();
        req_valid = 4'b1111;
        req_addr[0] = 10'h055;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready k=%0d got=%b exp=0000", k, req_ready); end
            checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we k=%0d got=%b exp=0", k, ram_we); end
            checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp k=%0d got=%b exp=0000", k, rsp_valid); end
            checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt_id k=%0d got=%0d exp=0", k, gnt_id); end
        end
        aresetn = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
        cyc();
        checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_first_gnt_id got=%0d exp=0", gnt_id); end
        checks++; if (ram_addr !== 10'h055) begin errors++; $display("FAIL reset_first_addr got=%h exp=055", ram_addr); end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL reset_second_grant got=%b exp=0010", req_ready); end
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_v;
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) req_addr[i] = 10'(i * 16);
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_v = 4'b0001 << (k % 4);
            checks++; if (req_ready !== exp_v) begin errors++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, exp_v); end
            if (k >= 1) begin
                checks++; if (gnt_id !== 2'((k - 1) % 4)) begin errors++; $display("FAIL rr_gnt_id k=%0d got=%0d exp=%0d", k, gnt_id, (k - 1) % 4); end
                checks++; if (ram_addr !== 10'(((k - 1) % 4) * 16) || ram_we !== 1'b0) begin errors++; $display("FAIL rr_cmd k=%0d got=%h/%b exp=%h/0", k, ram_addr, ram_we, ((k - 1) % 4) * 16); end
            end
            if (k >= 2) begin
                exp_v = 4'b0001 << ((k - 2) % 4);
                checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL rr_rsp k=%0d got=%b exp=%b", k, rsp_valid, exp_v); end
            end
            cyc();
        end
        clear_inputs();
    endtask

    task automatic test_write_read();
        do_reset();
        req_valid    = 4'b0010;
        req_we       = 4'b0010;
        req_addr[1]  = 10'h3FF;
        req_wdata[1] = 18'h2A5A5;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wr_ready got=%b exp=0010", req_ready); end
        cyc();
        clear_inputs();
        req_valid   = 4'b0100;
        req_addr[2] = 10'h3FF;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rd_ready got=%b exp=0100", req_ready); end
        checks++; if (ram_we !== 1'b1 || ram_addr !== 10'h3FF || ram_din !== 18'h2A5A5 || gnt_id !== 2'd1) begin
            errors++; $display("FAIL wr_cmd got we=%b addr=%h din=%h id=%0d exp we=1 addr=3ff din=2a5a5 id=1", ram_we, ram_addr, ram_din, gnt_id);
        end
        cyc();
        clear_inputs();
        #1;
        checks++; if (ram_we !== 1'b0 || ram_addr !== 10'h3FF || gnt_id !== 2'd2) begin
            errors++; $display("FAIL rd_cmd got we=%b addr=%h id=%0d exp we=0 addr=3ff id=2", ram_we, ram_addr, gnt_id);
        end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL wr_no_rsp got=%b exp=0000", rsp_valid); end
        cyc();
        checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL rd_rsp_valid got=%b exp=0100", rsp_valid); end
        checks++; if (rsp_rdata !== 18'h2A5A5) begin errors++; $display("FAIL rd_rsp_data got=%h exp=2a5a5", rsp_rdata); end
        cyc();
        checks++; if (rsp_valid !== 4'b0000 || ram_addr !== 10'h3FF) begin errors++; $display("FAIL idle_hold got rsp=%b addr=%h exp rsp=0000 addr=3ff", rsp_valid, ram_addr); end
    endtask

    task automatic test_lock();
        do_reset();
        req_valid   = 4'b0100;
        req_addr[2] = 10'h005;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL lock_pre_ready got=%b exp=0100", req_ready); end
        cyc();
        req_valid   = 4'b1011;
        req_we      = 4'b1000;
        req_lock    = 4'b1000;
        req_addr[3] = 10'h010;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL lock_beat1_ready got=%b exp=1000", req_ready); end
        cyc();
        req_addr[3] = 10'h011;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL lock_beat2_ready got=%b exp=1000", req_ready); end
        checks++; if (ram_we !== 1'b1 || ram_addr !== 10'h010 || gnt_id !== 2'd3) begin errors++; $display("FAIL lock_beat1_cmd got we=%b addr=%h id=%0d exp we=1 addr=010 id=3", ram_we, ram_addr, gnt_id); end
        checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL lock_pre_rsp got=%b exp=0100", rsp_valid); end
        cyc();
        req_valid = 4'b0011;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL lock_bubble_ready got=%b exp=0000", req_ready); end
        checks++; if (ram_addr !== 10'h011) begin errors++; $display("FAIL lock_beat2_cmd got=%h exp=011", ram_addr); end
        cyc();
        req_valid   = 4'b1011;
        req_addr[3] = 10'h012;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL lock_beat3_ready got=%b exp=1000", req_ready); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL lock_bubble_we got=%b exp=0", ram_we); end
        cyc();
        req_lock    = 4'b0000;
        req_addr[3] = 10'h013;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL lock_beat4_ready got=%b exp=1000", req_ready); end
        checks++; if (ram_addr !== 10'h012 || gnt_id !== 2'd3) begin errors++; $display("FAIL lock_beat3_cmd got addr=%h id=%0d exp addr=012 id=3", ram_addr, gnt_id); end
        cyc();
        req_valid = 4'b0011;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL lock_release_ready got=%b exp=0001", req_ready); end
        checks++; if (ram_addr !== 10'h013 || ram_we !== 1'b1) begin errors++; $display("FAIL lock_beat4_cmd got addr=%h we=%b exp addr=013 we=1", ram_addr, ram_we); end
        cyc();
        #1;
        checks++; if (gnt_id !== 2'd0 || ram_we !== 1'b0) begin errors++; $display("FAIL lock_after_gnt got id=%0d we=%b exp id=0 we=0", gnt_id, ram_we); end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL lock_after_ready got=%b exp=0010", req_ready); end
        clear_inputs();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_valid   = 4'b0001;
        req_addr[0] = 10'h007;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ready got=%b exp=0001", req_ready); end
        cyc();
        aresetn = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset_ready got=%b exp=0000", req_ready); end
        cyc();
        checks++; if (rsp_valid !== 4'b0000 || ram_we !== 1'b0 || gnt_id !== 2'd0) begin
            errors++; $display("FAIL mid_t2 got rsp=%b we=%b id=%0d exp rsp=0000 we=0 id=0", rsp_valid, ram_we, gnt_id);
        end
        aresetn = 1'b1;
        clear_inputs();
        for (int k = 0; k < 2; k++) begin
            cyc();
            checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_after k=%0d got=%b exp=0000", k, rsp_valid); end
        end
    endtask

    task automatic test_sparse_wrap();
        do_reset();
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL sparse_pre got=%b exp=0100", req_ready); end
        cyc();
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL sparse_r3 got=%b exp=1000", req_ready); end
        cyc();
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL sparse_r0 got=%b exp=0001", req_ready); end
        checks++; if (gnt_id !== 2'd3) begin errors++; $display("FAIL sparse_gnt3 got=%0d exp=3", gnt_id); end
        cyc();
        req_valid = 4'b1111;
        #1;
        checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL sparse_gnt0 got=%0d exp=0", gnt_id); end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL sparse_wrap_ptr got=%b exp=0010", req_ready); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write_read();
        test_lock();
        test_reset_midflight();
        test_sparse_wrap();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsram_port_arbiter.md
# lsram_port_arbiter

Round-robin arbiter that shares one port of an LSRAM block (dual-port or two-port wrapper, port A side) between NUM_REQ requesters. Each requester issues single-beat reads or writes over a valid/ready handshake. The arbiter registers the winning command onto the RAM port and routes the read data back to the issuing requester, tagged with its one-hot response strobe. An optional lock lets one requester hold the port for back-to-back beats.

## Interface
- NUM_REQ, 4, number of requesters, 2..8
- MODE, LSRAM_package::mode_type 1Kx18, LSRAM geometry
- DATA_WIDTH, LSRAM_package::data_width_fn(MODE), word width
- ADDR_WIDTH, LSRAM_package::addr_width_fn(MODE), address width

- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_lock  in  NUM_REQ  hold the grant after this beat
- req_addr  in  [NUM_REQ-1:0][ADDR_WIDTH-1:0]  per-requester address
- req_wdata  in  [NUM_REQ-1:0][DATA_WIDTH-1:0]  per-requester write data
- rsp_valid  out  NUM_REQ  one-hot read-data strobe
- rsp_rdata  out  DATA_WIDTH  read data, shared by all requesters
- ram_we  out  1  to RAM awe
- ram_addr  out  ADDR_WIDTH  to RAM aaddr
- ram_din  out  DATA_WIDTH  to RAM adin
- ram_dout  in  DATA_WIDTH  from RAM adout (registered inside RAM, 1-cycle latency)
- gnt_id  out  $clog2(NUM_REQ)  index of the requester driving ram_* this cycle (debug)

## Operation
- **Handshake.**
  - A beat transfers when req_valid[i] && req_ready[i].
  - req_ready is combinational from req_valid, the round-robin pointer and the lock state.
  - At most one bit of req_ready is high per cycle.
  - Requesters must not make req_valid depend on req_ready.
- **Round-robin.**
  - ptr holds the index after the last granted requester.
  - The grant goes to the first valid requester scanning ptr, ptr+1, … with modulo NUM_REQ wrap.
  - On a handshake, ptr = (granted index + 1) mod NUM_REQ. With no handshake, ptr is unchanged.
- **Lock.**
  - A handshake with req_lock[i]=1 sets lock_owner=i.
  - While locked, only requester i can be granted.
  - If i is not valid while locked, no grant is made that cycle (bubble) and the lock is retained.
  - The lock clears on a handshake by i with req_lock[i]=0, or on reset.
  - ptr still updates on locked handshakes.
- **Command register.**
  - On a handshake, ram_we, ram_addr, ram_din and gnt_id load the winner's fields on the next edge.
  - With no handshake, ram_we is 0. ram_addr and ram_din hold their previous values.
- **Read return.**
  - A 2-stage tag pipeline carries {is_read, id}.
  - When stage 2 holds is_read, rsp_valid[id]=1 and rsp_rdata=ram_dout, passed through combinationally.
  - Writes produce no response.
  - There is no response backpressure; a requester must sink the strobe.
- **Ordering.**
  - A write accepted in cycle T followed by a read of the same address accepted in T+1 or later returns the new data.
  - Responses return in acceptance order.

## Timing
- **Reset values** (while aresetn=0 at an edge):
  - ram_we=0, ram_addr=0, ram_din=0, gnt_id=0.
  - Tag pipeline cleared, so rsp_valid=0.
  - ptr=0, lock cleared.
  - req_ready is forced to 0 while aresetn=0.
- **Latency:**
  - Handshake in cycle T.
  - ram_* valid in T+1.
  - RAM samples at the end of T+1.
  - rsp_valid/rsp_rdata in T+2.
- **Throughput:** one beat per cycle sustained, including alternating requesters and read/write mixes.
- **Reset mid-operation:** in-flight reads are dropped, and no rsp_valid is asserted for them after reset deasserts.
- **Simultaneous events:** the lock-release handshake and a new arbitration cannot occur in the same cycle. The cycle after release arbitrates normally from the updated ptr.
- **Empty:** with no valid requester, no state changes except ram_we=0 and the tag pipeline advancing.

## Structure
- Use the existing LSRAM_package: mode_type, data_width_fn and addr_width_fn.
- Add to the package a function rr_pick(valid, ptr) that returns {found, index}. It is shared with future port schedulers.
- One sub-module: lsram_rr_arbiter. It holds ptr, the lock state and combinational req_ready/grant index, parameterised on NUM_REQ.
- The top level holds the command register and the tag pipeline.

## Test plan
- **Reset:**
  - Stimulus: aresetn=0 for 3 cycles with all req_valid=1.
  - Required: req_ready=0, ram_we=0, rsp_valid=0. After release, the first grant goes to requester 0.
- **Round-robin:**
  - Stimulus: all 4 requesters continuously valid with reads.
  - Required: grants in order 0,1,2,3,0,…; rsp_valid one-hot follows the same order 2 cycles later.
- **Write/read:**
  - Stimulus: requester 1 writes 0x2A5A5 to address 0x3FF, then requester 2 reads 0x3FF the next cycle.
  - Required: rsp_valid[2] two cycles after the read handshake, with rsp_rdata=0x2A5A5.
- **Lock:**
  - Stimulus: requester 3 issues 4 beats with req_lock=1,1,1,0, with a 1-cycle valid gap after beat 2; requesters 0 and 1 are valid throughout.
  - Required: no grant to 0 or 1 until after beat 4, with a bubble during the gap. Requester 0 is granted next.
- **Reset mid-flight:**
  - Stimulus: read accepted in T, aresetn=0 in T+1.
  - Required: no rsp_valid in T+2 or later.
- **Sparse and wrap:**
  - Stimulus: only requester 3 valid, ptr=3, then only requester 0 valid.
  - Required: grant 3, then 0, with ptr wrapping to 1.
